pe: RTL and testbench
=====================

Name: pe

Overview:
- 8x8 output-tile convolution processing element: 64 output pixels in parallel.
- Each pixel computes a 64-channel signed 8-bit dot product against a shared 64-entry weight line, combined with a 32-bit external partial sum per op.
- Issued once per 3x3 kernel tap; the controller feeds the result back as partial sum over 9 cycles to build a full 3x3x64 convolution.
- Companion leaf mux_3x3 (required, same deliverable) selects one tap byte from a 3x3 window.

Parameters:
- None; geometry fixed: 8x8 pixels, 64 channels, 8-bit data/weights, 32-bit accumulators.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  clock enable; low holds all state.
- data_valid  in  1  update qualifier; low holds data_out.
- data_in  in  32768  signed bytes; element (x,y,ch), i = x+8y+64ch, at [8i+7:8i]; x,y 0..7, ch 0..63.
- weight_line  in  512  signed bytes; channel ch weight at [8ch+7:8ch].
- data_out  out  2048  signed 32-bit result; pixel p = x+8y at [32p+31:32p].
- op  in  2  operation select.
- inter_data  in  2048  signed 32-bit partial sum per pixel, same packing as data_out.
- mux_3x3 ports: in_data in 72, num in 4, out_data out 8.

Behaviour:
- Pixel dot product: dot[p] = sum over ch of data_in(p,ch)*weight_line(ch).
  - Signed 8x8 -> 16-bit products; 64-term sum exact in 22 bits; sign-extended to 32.
- Result by op, all adds mod 2^32 (wrap, no saturation):
  - 00 accumulate: inter_data[p] + dot[p].
  - 01 load: dot[p].
  - 10 pass: inter_data[p].
  - 11 accumulate+ReLU: max(0, inter_data[p] + dot[p]).
- data_out registered: on rising clk when ena=1 and data_valid=1, data_out <= result; otherwise hold.
- Latency: 1 cycle from inputs to data_out.
- Pixels independent; no cross-pixel interaction.
- rst_n=0 clears data_out to 0 immediately, regardless of clk/ena; mid-operation reset discards partial results.
- First edge after rst_n release loads normally.
- mux_3x3 (combinational):
  - num=k, 0..8 -> out_data = in_data[8(9-k)-1 : 8(8-k)]; tap 0 is the MSB byte.
  - Taps row-major: k = 3*row + col.
  - num 9..15 -> out_data = 0.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle -> data_out all 0 before next edge; stays 0 while rst_n=0.
- Load: all data_in=1, all weights=2, op=01, ena=1, data_valid=1 -> every pixel 128 after one edge.
- Accumulate: data_in=-128, weights=-128, inter_data=5, op=00 -> every pixel 64*16384+5 = 1048581.
- Wrap/ReLU: data_in=127, weights=-128, inter_data=0, op=11 -> 0.
  - Same with op=00 -> -1040384.
  - inter_data=0x7FFFFFFF, dot=1, op=00 -> 0x80000000.
- Hold: ena=0 or data_valid=0 with changing inputs -> data_out unchanged; op=10, inter_data=pixel index -> data_out[p]=p.
- mux_3x3 and full conv: in_data=0x010203040506070809, num=0 -> 0x01, num=8 -> 0x09, num=12 -> 0x00.
  - Full conv: random 10x10x64 map, random 3x3x64 weights, nine op=00 cycles (tap k, weights k*64..k*64+63, inter_data fed from data_out).
  - Expect each pixel = golden 3x3x64 convolution.

Source files
------------

// File: rtl/pe.sv
// 8x8 output-tile convolution PE: 64 pixels x 64-channel int8 dot products.
// Also holds mux_3x3, the tap-byte selector for a 3x3 window.
module mux_3x3 (
  input  logic [71:0] in_data,
  input  logic [3:0]  num,
  output logic [7:0]  out_data
);
  always_comb begin
    out_data = '0;
    unique case (num)
      4'd0:    out_data = in_data[71:64];
      4'd1:    out_data = in_data[63:56];
      4'd2:    out_data = in_data[55:48];
      4'd3:    out_data = in_data[47:40];
      4'd4:    out_data = in_data[39:32];
      4'd5:    out_data = in_data[31:24];
      4'd6:    out_data = in_data[23:16];
      4'd7:    out_data = in_data[15:8];
      4'd8:    out_data = in_data[7:0];
      default: out_data = '0;
    endcase
  end
endmodule

module pe (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  input  logic           data_valid,
  input  logic [32767:0] data_in,
  input  logic [511:0]   weight_line,
  input  logic [1:0]     op,
  input  logic [2047:0]  inter_data,
  output logic [2047:0]  data_out
);
  logic [2047:0] result;

  for (genvar p = 0; p < 64; p++) begin : g_px
    logic signed [21:0] dot;
    logic signed [31:0] part;
    logic signed [31:0] acc;

    always_comb begin
      logic signed [7:0]  a;
      logic signed [7:0]  w;
      logic signed [15:0] prod;
      dot  = '0;
      a    = '0;
      w    = '0;
      prod = '0;
      for (int c = 0; c < 64; c++) begin
        a    = data_in[8*(p+64*c) +: 8];
        w    = weight_line[8*c +: 8];
        prod = a * w;
        dot  = dot + {{6{prod[15]}}, prod};
      end
    end

    assign part = inter_data[32*p +: 32];
    // 32-bit add wraps mod 2^32 by construction
    assign acc  = part + {{10{dot[21]}}, dot};

    always_comb begin
      result[32*p +: 32] = acc;
      unique case (op)
        2'b00: result[32*p +: 32] = acc;
        2'b01: result[32*p +: 32] = {{10{dot[21]}}, dot};
        2'b10: result[32*p +: 32] = part;
        2'b11: result[32*p +: 32] = acc[31] ? 32'd0 : acc;
        default: result[32*p +: 32] = acc;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      data_out <= '0;
    else if (ena && data_valid)
      data_out <= result;
  end
endmodule

// File: tb/tb_pe.sv
// Directed bench for pe and mux_3x3.
// Ends with a full 9-tap 3x3x64 convolution against a golden model.
module tb_pe;
  logic           clk = 1'b0;
  logic           rst_n;
  logic           ena;
  logic           data_valid;
  logic [32767:0] data_in;
  logic [511:0]   weight_line;
  logic [1:0]     op;
  logic [2047:0]  inter_data;
  logic [2047:0]  data_out;

  logic [71:0] m_in;
  logic [3:0]  m_num;
  logic [7:0]  m_out;

  int checks   = 0;
  int failures = 0;

  byte signed map [10][10][64];
  byte signed wt  [9][64];

  pe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .data_valid  (data_valid),
    .data_in     (data_in),
    .weight_line (weight_line),
    .op          (op),
    .inter_data  (inter_data),
    .data_out    (data_out)
  );

  mux_3x3 u_mux (
    .in_data  (m_in),
    .num      (m_num),
    .out_data (m_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] exp);
    for (int p = 0; p < 64; p++)
      chk($sformatf("%s[%0d]", tag, p), data_out[32*p +: 32], exp);
  endtask

  task automatic fill_data(input logic [7:0] v);
    for (int i = 0; i < 4096; i++) data_in[8*i +: 8] = v;
  endtask

  task automatic fill_w(input logic [7:0] v);
    for (int c = 0; c < 64; c++) weight_line[8*c +: 8] = v;
  endtask

  task automatic fill_inter(input logic [31:0] v);
    for (int p = 0; p < 64; p++) inter_data[32*p +: 32] = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; data_valid = 1'b1; op = 2'b01;
    fill_data(8'd1); fill_w(8'd2); fill_inter(32'd0);
    m_in = 72'h010203040506070809; m_num = 4'd0;
    step();
    chk_all("rst", 32'd0);

    @(negedge clk) rst_n = 1'b1;
    step();
    chk_all("load", 32'd128);

    @(negedge clk);
    fill_data(8'h80); fill_w(8'h80); fill_inter(32'd5); op = 2'b00;
    step();
    chk_all("acc", 32'd1048581);

    @(negedge clk);
    fill_data(8'd127); fill_inter(32'd0); op = 2'b11;
    step();
    chk_all("relu", 32'd0);

    @(negedge clk) op = 2'b00;
    step();
    chk_all("neg", -32'sd1040384);

    @(negedge clk);
    fill_data(8'd1); fill_w(8'd0); weight_line[7:0] = 8'd1;
    fill_inter(32'h7FFFFFFF);
    step();
    chk_all("wrap", 32'h80000000);

    @(negedge clk);
    ena = 1'b0; fill_data(8'd3); fill_w(8'd3); fill_inter(32'd9);
    step();
    chk_all("hold_ena", 32'h80000000);

    @(negedge clk);
    ena = 1'b1; data_valid = 1'b0; op = 2'b01;
    step();
    chk_all("hold_dv", 32'h80000000);

    @(negedge clk);
    data_valid = 1'b1; op = 2'b10;
    for (int p = 0; p < 64; p++) inter_data[32*p +: 32] = p;
    step();
    for (int p = 0; p < 64; p++)
      chk($sformatf("pass[%0d]", p), data_out[32*p +: 32], p);

    // asynchronous reset asserted mid-cycle
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all("arst", 32'd0);
    step();
    chk_all("arst_hold", 32'd0);
    @(negedge clk) rst_n = 1'b1;

    m_num = 4'd0;  #1 chk("mux0", 32'(m_out), 32'h01);
    m_num = 4'd4;  #1 chk("mux4", 32'(m_out), 32'h05);
    m_num = 4'd8;  #1 chk("mux8", 32'(m_out), 32'h09);
    m_num = 4'd12; #1 chk("mux12", 32'(m_out), 32'h00);

    for (int y = 0; y < 10; y++)
      for (int x = 0; x < 10; x++)
        for (int c = 0; c < 64; c++)
          map[y][x][c] = byte'($urandom);
    for (int k = 0; k < 9; k++)
      for (int c = 0; c < 64; c++)
        wt[k][c] = byte'($urandom);

    op = 2'b00;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      for (int c = 0; c < 64; c++) weight_line[8*c +: 8] = wt[k][c];
      for (int y = 0; y < 8; y++)
        for (int x = 0; x < 8; x++)
          for (int c = 0; c < 64; c++)
            data_in[8*(x+8*y+64*c) +: 8] = map[y+k/3][x+k%3][c];
      if (k == 0) fill_inter(32'd0);
      else inter_data = data_out;
      step();
    end

    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        int sum;
        sum = 0;
        for (int k = 0; k < 9; k++)
          for (int c = 0; c < 64; c++)
            sum += int'(map[y+k/3][x+k%3][c]) * int'(wt[k][c]);
        chk($sformatf("conv[%0d,%0d]", x, y),
            data_out[32*(x+8*y) +: 32], 32'(sum));
      end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
